// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// the fetch-queue entry layout and the fixed NOP/PC step values.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between fetch and decode. A flush empties it; a push in the
// same cycle as a flush lands as the single surviving entry.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    wr_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (flush || !full || pop);
  assign do_pop  = pop && !empty && !flush;
  assign wr_idx  = flush ? '0 : wr_ptr;

  // Empty queue presents zeros so the head is defined straight out of reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC generator and fetch stage feeding decode through fetch_queue.
// Optional misaligned-target trap entries: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          IMEM_WORDS  = 10,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        if_misaligned
`endif
);

  localparam int          BW         = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [BW-1:0] boot_cnt, boot_nxt;
  logic          q_push, q_flush, q_full, q_empty, pop;
  fetch_entry_t  q_din, q_head;

  assign imem_addr = {2'b00, pc[31:2]};
  assign pop       = if_valid && if_ready;
  assign if_valid  = !q_empty;
  assign if_pc     = q_head.pc;
  assign if_instr  = q_head.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_misaligned = q_head.misaligned;
`else
  logic unused_bits;
  assign unused_bits = ^{redirect_target[1:0], q_head.misaligned};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      boot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      boot_cnt <= boot_nxt;
    end
  end

  // Redirect outranks pop, push and the end-of-memory check.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    boot_nxt  = boot_cnt;
    q_push    = 1'b0;
    q_flush   = 1'b0;
    q_din     = '{pc: pc, instr: imem_rdata, misaligned: 1'b0};
    case (state)
      BOOT: begin
        boot_nxt = boot_cnt + BW'(1);
        if (redirect_valid) pc_nxt = {redirect_target[31:2], 2'b00};
        if (boot_cnt == BOOT_LAST) state_nxt = FETCH;
      end
      FETCH, HALT: begin
        if (redirect_valid) begin
          q_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          pc_nxt = redirect_target;
          if (redirect_target[1:0] != 2'b00) begin
            q_push    = 1'b1;
            q_din     = '{pc: redirect_target, instr: NOP_INSTR, misaligned: 1'b1};
            state_nxt = HALT;
          end else begin
            state_nxt = FETCH;
          end
`else
          pc_nxt    = {redirect_target[31:2], 2'b00};
          state_nxt = FETCH;
`endif
        end else if (state == FETCH) begin
          if (pc[31:2] >= IMEM_LIMIT) begin
            state_nxt = HALT;
          end else if (!q_full || pop) begin
            q_push = 1'b1;
            pc_nxt = pc + PC_STEP;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push && !reset),
    .pop   (pop),
    .flush (q_flush),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a 10-word memory holding word[k]=k.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd10) ? imem_addr : 32'hBAD0_0000;

  instr_fetch_unit #(
    .RESET_PC(32'h0), .IMEM_WORDS(10), .QUEUE_DEPTH(2), .BOOT_CYCLES(1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .if_misaligned   (if_misaligned)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input int first);
    for (int k = first; k < 10; k++) exp_q.push_back('{pc: 32'(4 * k), instr: 32'(k), mis: 1'b0});
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic expect_idle(input string name);
    repeat (4) tick();
    @(negedge clk);
    check({name, "_idle_valid"}, {31'd0, if_valid}, 32'd0);
    tick();
  endtask

  // Monitor: every accepted head is checked against the next expected entry.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pc %h instr %h expected no output", if_pc, if_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", if_pc, e.pc);
        check("out_instr", if_instr, e.instr);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("out_misaligned", {31'd0, if_misaligned}, {31'd0, e.mis});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset state, then free-running stream until HALT
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    tick();
    expect_stream(0);
    reset = 1'b0;
    if_ready = 1'b1;
    wait_drain("t1");
    expect_idle("t1");

    // 2. backpressure: two entries queued, fetch address held, head stable
    reset = 1'b1;
    if_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge clk);
      if (k >= 3) begin
        check("t2_valid", {31'd0, if_valid}, 32'd1);
        check("t2_pc_stable", if_pc, 32'd0);
        check("t2_instr_stable", if_instr, 32'd0);
        check("t2_addr_hold", imem_addr, 32'd2);
      end
    end
    tick();
    expect_stream(0);
    if_ready = 1'b1;
    wait_drain("t2");
    expect_idle("t2");

    // 3. redirect to 0x14 with a full queue
    reset = 1'b1;
    if_ready = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    expect_stream(5);
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h14;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_flush_valid", {31'd0, if_valid}, 32'd0);
    wait_drain("t3");
    expect_idle("t3");

    // 4. redirect out of HALT
    expect_stream(2);
    redirect_valid = 1'b1;
    redirect_target = 32'h8;
    tick();
    redirect_valid = 1'b0;
    wait_drain("t4");
    expect_idle("t4");

    // 5. misaligned redirect target
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_q.push_back('{pc: 32'h6, instr: 32'h13, mis: 1'b1});
`else
    expect_stream(1);
`endif
    redirect_valid = 1'b1;
    redirect_target = 32'h6;
    tick();
    redirect_valid = 1'b0;
    wait_drain("t5");
    expect_idle("t5");

    // 6. reset mid-stream with a full queue
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("t6_full_valid", {31'd0, if_valid}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_reset_valid", {31'd0, if_valid}, 32'd0);
    tick();
    expect_stream(0);
    if_ready = 1'b1;
    wait_drain("t6");
    expect_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
